// File: rtl/handshake_tx_pkg.sv
// Shared constants and FSM encoding for the 4-phase handshake transmitter.
package handshake_tx_pkg;

   localparam int unsigned DefWidth   = 10;
   localparam int unsigned DefDepth   = 2;
   localparam int unsigned DefTimeout = 255;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StSetup   = 2'd1,
      StReq     = 2'd2,
      StRelease = 2'd3
   } state_e;

endpackage

// File: rtl/handshake_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, cleared by reset.
module handshake_sync2 #(
   parameter int unsigned Width = 1
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/handshake_tx.sv
// Queued event transmitter driving a 4-phase req/ack handshake to an asynchronous receiver,
// with per-phase timeout abort.
module handshake_tx
   import handshake_tx_pkg::*;
#(
   parameter int unsigned WIDTH   = DefWidth,
   parameter int unsigned DEPTH   = DefDepth,
   parameter int unsigned TIMEOUT = DefTimeout
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             req_out,
   output logic [WIDTH-1:0] data_out,
   input  logic             ack_in,
   output logic             busy,
   output logic             drop_err,
   output logic             timeout_err
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic             ack_s;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push, pop;
   state_e           state_q;
   logic [TmrW-1:0]  tmr_q;
   logic             req_q, drop_q, timeout_q;
   logic [WIDTH-1:0] data_q;

   handshake_sync2 #(
      .Width (1)
   ) u_ack_sync (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .d_i     (ack_in),
      .q_o     (ack_s)
   );

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_ready = (count_q < CntW'(DEPTH));
   assign push     = in_valid & in_ready;
   // A stuck-high ack holds off the next handshake until the receiver has released.
   assign pop      = (state_q == StIdle) && (count_q != '0) && !ack_s;
   assign busy     = (state_q != StIdle) || (count_q != '0);

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         tmr_q     <= '0;
         req_q     <= 1'b0;
         data_q    <= '0;
         drop_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         // in_ready reflects count_q only, so a same-cycle pop never rescues the event.
         drop_q    <= in_valid & ~in_ready;
         timeout_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  data_q  <= mem_q[rd_ptr_q];
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               req_q   <= 1'b1;
               tmr_q   <= '0;
               state_q <= StReq;
            end
            StReq: begin
               if (ack_s) begin
                  req_q   <= 1'b0;
                  tmr_q   <= '0;
                  state_q <= StRelease;
               end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
                  req_q     <= 1'b0;
                  timeout_q <= 1'b1;
                  state_q   <= StIdle;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            StRelease: begin
               if (!ack_s) begin
                  state_q <= StIdle;
               end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
                  timeout_q <= 1'b1;
                  state_q   <= StIdle;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_out     = req_q;
   assign data_out    = data_q;
   assign drop_err    = drop_q;
   assign timeout_err = timeout_q;

endmodule
